// File: rtl/core_power_scheduler.sv
// Per-core power/clock-enable sequencer: admits up to MAX_ACTIVE cores round-robin and
// walks each through OFF -> WAKE -> ON -> DRAIN -> OFF with fixed warm-up and drain times.
module core_power_scheduler #(
    parameter int N          = 4,
    parameter int MAX_ACTIVE = 2,
    parameter int WAKE_CYC   = 3,
    parameter int DRAIN_CYC  = 2,
    localparam int CW        = $clog2(N + 1)
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  pwr_on,
    output logic [N-1:0]  clk_en,
    output logic [CW-1:0] active_cnt
);

    localparam int MAXC = (WAKE_CYC > DRAIN_CYC) ? WAKE_CYC : DRAIN_CYC;
    localparam int TW   = $clog2(MAXC + 1);
    localparam int PW   = (N > 1) ? $clog2(N) : 1;

    // Gray-ordered so every normal transition flips a single state bit
    localparam logic [1:0] ST_OFF   = 2'b00;
    localparam logic [1:0] ST_WAKE  = 2'b01;
    localparam logic [1:0] ST_ON    = 2'b11;
    localparam logic [1:0] ST_DRAIN = 2'b10;

    localparam logic [TW-1:0] WAKE_LD  = TW'(WAKE_CYC);
    localparam logic [TW-1:0] DRAIN_LD = TW'(DRAIN_CYC);
    localparam logic [TW-1:0] CNT_ONE  = TW'(1);
    localparam logic [CW-1:0] MAX_LIM  = CW'(MAX_ACTIVE);

    logic [N-1:0]  is_off;
    logic [N-1:0]  grant;
    logic [N-1:0]  busy_next;
    logic [N-1:0]  pwr_on_reg;
    logic [N-1:0]  clk_en_reg;
    logic [PW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [PW-1:0] idx_p;
    logic [CW-1:0] active_cnt_reg, active_cnt_next;
    logic          found;
    int            idx;

    // Occupancy comes from the current registers, so a core leaving DRAIN this edge
    // still holds its slot; the freed slot is grantable one cycle later.
    always_comb begin
        grant       = '0;
        rr_ptr_next = rr_ptr_reg;
        found       = 1'b0;
        idx         = 0;
        idx_p       = '0;
        if (active_cnt_reg < MAX_LIM) begin
            for (int off = 0; off < N; off++) begin
                idx = int'(rr_ptr_reg) + off;
                if (idx >= N) idx = idx - N;
                idx_p = PW'(idx);
                if (!found && req[idx_p] && is_off[idx_p]) begin
                    found        = 1'b1;
                    grant[idx_p] = 1'b1;
                    rr_ptr_next  = (idx == N - 1) ? '0 : PW'(idx + 1);
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_core
            logic [1:0]    state_reg, state_next;
            logic [TW-1:0] cnt_reg, cnt_next;

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    ST_OFF: begin
                        if (grant[gi]) begin
                            state_next = ST_WAKE;
                            cnt_next   = WAKE_LD;
                        end
                    end
                    ST_WAKE: begin
                        // Warm-up always runs to completion; req decides the exit only
                        if (cnt_reg <= CNT_ONE) begin
                            state_next = req[gi] ? ST_ON : ST_DRAIN;
                            cnt_next   = req[gi] ? '0 : DRAIN_LD;
                        end else begin
                            cnt_next = cnt_reg - CNT_ONE;
                        end
                    end
                    ST_ON: begin
                        if (!req[gi]) begin
                            state_next = ST_DRAIN;
                            cnt_next   = DRAIN_LD;
                        end
                    end
                    default: begin
                        if (cnt_reg <= CNT_ONE) begin
                            state_next = ST_OFF;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg - CNT_ONE;
                        end
                    end
                endcase
            end

            // Outputs are registered from the next state so they never glitch
            always_ff @(posedge clk_in or posedge reset) begin
                if (reset) begin
                    state_reg      <= ST_OFF;
                    cnt_reg        <= '0;
                    pwr_on_reg[gi] <= 1'b0;
                    clk_en_reg[gi] <= 1'b0;
                end else begin
                    state_reg      <= state_next;
                    cnt_reg        <= cnt_next;
                    pwr_on_reg[gi] <= (state_next != ST_OFF);
                    clk_en_reg[gi] <= (state_next == ST_ON);
                end
            end

            assign is_off[gi]    = (state_reg == ST_OFF);
            assign busy_next[gi] = (state_next != ST_OFF);
        end
    endgenerate

    assign active_cnt_next = CW'($countones(busy_next));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rr_ptr_reg     <= '0;
            active_cnt_reg <= '0;
        end else begin
            rr_ptr_reg     <= rr_ptr_next;
            active_cnt_reg <= active_cnt_next;
        end
    end

    assign pwr_on     = pwr_on_reg;
    assign clk_en     = clk_en_reg;
    assign active_cnt = active_cnt_reg;

endmodule

// File: tb/tb_core_power_scheduler.sv
// Bench for core_power_scheduler: constant vector tables, hand-built corner sequences and
// random requests, all cross-checked against a timestamp-based behavioural model.
module tb_core_power_scheduler;

    localparam int N          = 4;
    localparam int MAX_ACTIVE = 2;
    localparam int WAKE_CYC   = 3;
    localparam int DRAIN_CYC  = 2;
    localparam int CW         = $clog2(N + 1);

    logic          clk_in = 1'b0;
    logic          reset  = 1'b1;
    logic [N-1:0]  req    = '0;
    logic [N-1:0]  pwr_on;
    logic [N-1:0]  clk_en;
    logic [CW-1:0] active_cnt;

    always #5 clk_in = ~clk_in;

    core_power_scheduler #(
        .N(N), .MAX_ACTIVE(MAX_ACTIVE), .WAKE_CYC(WAKE_CYC), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .req(req),
        .pwr_on(pwr_on),
        .clk_en(clk_en),
        .active_cnt(active_cnt)
    );

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  pwr;
        logic [N-1:0]  clk;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // Model: phase 0=off 1=wake 2=on 3=drain, with the edge number at which it was entered
    int m_phase[N];
    int m_t[N];
    int m_rr;
    int m_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_phase[i] = 0;
            m_t[i]     = 0;
        end
        m_rr = 0;
    endfunction

    function automatic void model_step(input logic [N-1:0] r);
        int occ  = 0;
        int win  = -1;
        int best = N;
        for (int i = 0; i < N; i++) if (m_phase[i] != 0) occ++;
        if (occ < MAX_ACTIVE) begin
            for (int i = 0; i < N; i++) begin
                if (r[i] && m_phase[i] == 0 && ((i - m_rr + N) % N) < best) begin
                    best = (i - m_rr + N) % N;
                    win  = i;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            case (m_phase[i])
                1: if (m_cyc - m_t[i] == WAKE_CYC) begin
                       m_phase[i] = r[i] ? 2 : 3;
                       m_t[i]     = m_cyc;
                   end
                2: if (!r[i]) begin
                       m_phase[i] = 3;
                       m_t[i]     = m_cyc;
                   end
                3: if (m_cyc - m_t[i] == DRAIN_CYC) m_phase[i] = 0;
                default: ;
            endcase
        end
        if (win >= 0) begin
            m_phase[win] = 1;
            m_t[win]     = m_cyc;
            m_rr         = (win + 1) % N;
        end
        m_cyc++;
    endfunction

    task automatic check_model(input string tag);
        logic [N-1:0] ep = '0;
        logic [N-1:0] ec = '0;
        int           en = 0;
        for (int i = 0; i < N; i++) begin
            ep[i] = (m_phase[i] != 0);
            ec[i] = (m_phase[i] == 2);
            if (m_phase[i] != 0) en++;
        end
        check({tag, "_pwr_on"}, 32'(pwr_on), 32'(ep));
        check({tag, "_clk_en"}, 32'(clk_en), 32'(ec));
        check({tag, "_active_cnt"}, 32'(active_cnt), en);
    endtask

    task automatic step(input logic [N-1:0] r, input string tag);
        req = r;
        model_step(r);
        @(posedge clk_in);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_pwr_on", 32'(pwr_on), 0);
        check("reset_clk_en", 32'(clk_en), 0);
        check("reset_active_cnt", 32'(active_cnt), 0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
    endtask

    task automatic add(input int reps, input logic [N-1:0] r, input logic [N-1:0] p,
                       input logic [N-1:0] c, input logic [CW-1:0] n);
        vec_t v;
        v.req = r; v.pwr = p; v.clk = c; v.cnt = n;
        for (int i = 0; i < reps; i++) tbl.push_back(v);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tag);
            check($sformatf("%s_e%0d_pwr", tag, i), 32'(pwr_on), 32'(tbl[i].pwr));
            check($sformatf("%s_e%0d_clk", tag, i), 32'(clk_en), 32'(tbl[i].clk));
            check($sformatf("%s_e%0d_cnt", tag, i), 32'(active_cnt), 32'(tbl[i].cnt));
        end
        tbl.delete();
    endtask

    initial begin
        int           hi_cnt;
        logic         clk_seen;
        logic [N-1:0] r;
        logic [31:0]  m;

        model_reset();
        do_reset();

        // Single core: warm-up 3 edges, release at edge 10, drain 2 edges
        add(3, 4'b0001, 4'b0001, 4'b0000, 3'd1);
        add(7, 4'b0001, 4'b0001, 4'b0001, 3'd1);
        add(2, 4'b0000, 4'b0001, 4'b0000, 3'd1);
        add(1, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        run_table("single");

        do_reset();
        // Budget: all four request, only cores 0 and 1 are admitted
        add(1, 4'b1111, 4'b0001, 4'b0000, 3'd1);
        add(2, 4'b1111, 4'b0011, 4'b0000, 3'd2);
        add(1, 4'b1111, 4'b0011, 4'b0001, 3'd2);
        add(4, 4'b1111, 4'b0011, 4'b0011, 3'd2);
        run_table("budget");

        // Slot handoff: core0 released at edge 8, OFF after edge 10, core2 admitted edge 11
        step(4'b1110, "handoff");
        step(4'b1110, "handoff");
        step(4'b1110, "handoff");
        check("handoff_core0_off", 32'(pwr_on), 32'b0010);
        step(4'b1111, "handoff");
        check("handoff_core2_on", 32'(pwr_on), 32'b0110);

        // Fairness: core0 waits behind core3, then gets the following slot
        step(4'b1101, "fair");
        step(4'b1101, "fair");
        step(4'b1101, "fair");
        check("fair_core1_off", 32'(pwr_on), 32'b0100);
        step(4'b1101, "fair");
        check("fair_core3_first", 32'(pwr_on), 32'b1100);
        for (int i = 0; i < 4; i++) step(4'b1011, "fair");
        check("fair_core0_next", 32'(pwr_on), 32'b1001);

        // Async reset mid-cycle with core3 draining and core0 warming up
        step(4'b0011, "areset");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("areset_pwr_on", 32'(pwr_on), 0);
        check("areset_clk_en", 32'(clk_en), 0);
        check("areset_active_cnt", 32'(active_cnt), 0);
        @(negedge clk_in);
        reset = 1'b0;
        step(4'b1111, "areset");
        check("areset_rr_core0", 32'(pwr_on), 32'b0001);

        // Early release: one-cycle pulse on req[1]
        do_reset();
        hi_cnt   = 0;
        clk_seen = 1'b0;
        step(4'b0010, "early");
        if (pwr_on[1]) hi_cnt++;
        if (clk_en[1]) clk_seen = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step(4'b0000, "early");
            if (pwr_on[1]) hi_cnt++;
            if (clk_en[1]) clk_seen = 1'b1;
        end
        check("early_pwr_cycles", hi_cnt, WAKE_CYC + DRAIN_CYC);
        check("early_clk_never", 32'(clk_seen), 0);

        // Random requests with persistence: each bit toggles with probability 1/4
        do_reset();
        r = '0;
        for (int i = 0; i < 400; i++) begin
            m = $urandom & $urandom;
            r = r ^ m[N-1:0];
            step(r, "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
